ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the single-port 256x16 program/data RAM between two requesters:
//  port 0 = CPU datapath (MAR/RI/RO path), port 1 = external program loader/debug.
//  Req/Gnt/Ack handshake per port, round-robin arbitration, bounded bursts.
//  Drives CpuStall so the ControlUnit freezes its step counter while the CPU waits.
// PARAMETERS
//  AddrWidth  8   RAM address width
//  DataWidth  16  RAM/bus data width
//  MaxBurst   4   max accesses per grant before a waiting port preempts (>=1)
// PORTS
//  Clk        in   1          clock, all state on rising edge
//  Rst        in   1          asynchronous, active-high reset
//  Req[1:0]   in   2          per-port request; held high for whole access sequence
//  We[1:0]    in   2          per-port write enable (1=write, 0=read)
//  Addr0/1    in   AddrWidth  per-port address
//  WData0/1   in   DataWidth  per-port write data
//  Gnt[1:0]   out  2          registered grant, one-hot or zero
//  Ack[1:0]   out  2          registered, 1 cycle per completed access
//  RData      out  DataWidth  read data, valid when Ack[x] & ~We of that access
//  CpuStall   out  1          Req[0] & ~Gnt[0] (combinational)
//  RamAddr    out  AddrWidth  to RAM, muxed from owner
//  RamWe      out  1          to RAM, owner We & Req & Gnt
//  RamWData   out  DataWidth  to RAM, muxed from owner
//  RamRData   in   DataWidth  from RAM, sync read, 1-cycle latency
// BEHAVIOUR
//  Reset: state IDLE, Gnt=0, Ack=0, RData=0, BurstCnt=0, LastOwner=1 (CPU wins first tie).
//  RamWe=0 whenever Gnt=0; RamAddr/RamWData = port 0 values when idle (don't care).
//  FSM: IDLE -> OWN(x) -> IDLE.
//  - IDLE: if any Req, pick winner; Gnt[x]=1 next cycle (grant latency 1). Both
//    requesting: pick ~LastOwner. LastOwner<=x on grant.
//  - OWN(x): each cycle with Req[x]&Gnt[x] = one accepted access; RAM driven
//    combinationally from port x that cycle; Ack[x]=1 the following cycle;
//    read data registered into RData with that Ack. Throughput 1 access/cycle.
//  - BurstCnt increments per accepted access, cleared on grant.
//  - Release: Req[x] low -> no access that cycle, Gnt[x] drops next cycle, IDLE.
//  - Preempt: BurstCnt reaches MaxBurst and Req[~x] high -> Gnt[x] drops next
//    cycle, IDLE; other port granted the cycle after (one dead cycle between owners).
//    If Req[~x] low at MaxBurst: BurstCnt wraps to 0, x keeps grant.
//  - Requester must not change Addr/We/WData between acceptance and its Ack
//    only if Req stays high; a new access may be presented every Gnt cycle.
//  - Ack for the final access still issues the cycle after Gnt drops.
//  - Write then read same address on consecutive cycles: read returns new data
//    (arbiter never reorders; RAM write precedes read).
//  - Req deasserted without Gnt: request withdrawn, no state change.
//  - Reset mid-access: outputs return to reset values immediately; a write
//    already sampled by RAM is not undone; pending Ack is lost.
//  - Gnt never one-hot to both ports; Ack[x] never without prior accepted access.
// CONFIGURATION
//  ARB_FIXED_PRIORITY_EN defined: port 1 (loader) always wins in IDLE and is
//   never preempted (MaxBurst ignored for port 1); port 0 still preempted by
//   port 1 at MaxBurst. LastOwner unused.
//  Undefined: round-robin and MaxBurst apply symmetrically as above.
// TESTING
//  T1 reset: assert Rst mid-burst -> Gnt=0, Ack=0, RData=0, CpuStall=Req[0] same cycle.
//  T2 single: Req0 We0=1 Addr0=0x10 WData0=0xBEEF, then read 0x10 -> Gnt0 at +1,
//     Ack0 at +2 and +3, RData=0xBEEF on second Ack.
//  T3 tie: Req=2'b11 from reset -> Gnt0 first; after release Gnt1; next tie Gnt0.
//  T4 preempt: port1 reads 8 addrs 0x00..0x07, Req0 high throughout -> port1 gets
//     4 Acks, Gnt drops, one dead cycle, Gnt0; CpuStall high until Gnt0.
//  T5 no-contention burst: port0 6 accesses, Req1 low -> Gnt0 held, 6 Acks back-to-back.
//  T6 ARB_FIXED_PRIORITY_EN: same as T4 -> port1 completes all 8 accesses before Gnt0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares one single-port sync-read RAM between the CPU datapath
//               (port 0) and the program loader/debug port (port 1).
//               Req/Gnt/Ack handshake per port, round-robin arbitration and
//               bounded bursts. Drives CpuStall while the CPU waits for the RAM.
//               Optional build macro: ARB_FIXED_PRIORITY_EN (loader always wins
//               and is never preempted).
// Revision    : 1.0 - initial release
// ============================================================================
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [1:0]            Req,
    input  logic [1:0]            We,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] WData0,
    input  logic [DATA_WIDTH-1:0] WData1,
    output logic [1:0]            Gnt,
    output logic [1:0]            Ack,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  CpuStall,
    output logic [ADDR_WIDTH-1:0] RamAddr,
    output logic                  RamWe,
    output logic [DATA_WIDTH-1:0] RamWData,
    input  logic [DATA_WIDTH-1:0] RamRData
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_gnt;
    logic [CNT_W-1:0]      r_burst_cnt;
    logic [CNT_W-1:0]      w_burst_nxt;
    logic [CNT_W-1:0]      w_burst_inc;
    logic                  r_last_owner;
    logic                  w_last_nxt;
    logic                  w_win;
    logic [1:0]            r_ack;
    logic                  r_ack_rd;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  w_owner;
    logic                  w_acc;
    logic                  w_other_req;
    logic                  w_may_preempt;

    // Owner select; an idle arbiter points the RAM at port 0 with writes off
    assign w_owner     = r_gnt[1];
    assign w_acc       = Req[w_owner] & r_gnt[w_owner];
    assign w_other_req = Req[~w_owner];
    assign w_burst_inc = r_burst_cnt + CNT_W'(1);

`ifdef ARB_FIXED_PRIORITY_EN
    // Only the CPU can lose the RAM at the burst limit
    assign w_may_preempt = ~w_owner;
`else
    assign w_may_preempt = 1'b1;
`endif

    assign Gnt      = r_gnt;
    assign Ack      = r_ack;
    assign CpuStall = Req[0] & ~r_gnt[0];
    assign RamAddr  = w_owner ? Addr1  : Addr0;
    assign RamWData = w_owner ? WData1 : WData0;
    assign RamWe    = w_acc & We[w_owner];

    // RAM output register already aligns read data with Ack; hold it afterwards
    assign RData = (r_ack_rd && (r_ack != 2'b00)) ? RamRData : r_rdata;

    // Next-state, burst counting and winner selection
    always_comb begin
        w_state_nxt = r_state;
        w_burst_nxt = r_burst_cnt;
        w_last_nxt  = r_last_owner;
        w_win       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Req != 2'b00) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    w_win = Req[1];
`else
                    w_win = (Req == 2'b11) ? ~r_last_owner : Req[1];
`endif
                    w_state_nxt = w_win ? ST_OWN1 : ST_OWN0;
                    w_burst_nxt = '0;
                    w_last_nxt  = w_win;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!Req[w_owner]) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_burst_inc == CNT_W'(MAX_BURST)) begin
                    w_burst_nxt = '0;
                    if (w_other_req && w_may_preempt) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_burst_nxt = w_burst_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant and burst registers
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state      <= ST_IDLE;
            r_gnt        <= 2'b00;
            r_burst_cnt  <= '0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= {w_state_nxt == ST_OWN1, w_state_nxt == ST_OWN0};
            r_burst_cnt  <= w_burst_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    // One Ack per accepted access, issued the following cycle; capture read data
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_ack    <= 2'b00;
            r_ack_rd <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_ack    <= {w_acc & w_owner, w_acc & ~w_owner};
            r_ack_rd <= w_acc & ~We[w_owner];
            if (r_ack_rd && (r_ack != 2'b00)) begin
                r_rdata <= RamRData;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Self-checking bench for ram_port_arbiter with a sync-read RAM
//               model, per-port requester drivers and an Ack scoreboard.
//               Honours ARB_FIXED_PRIORITY_EN for arbitration expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic [1:0]  gnt, ack;
    logic [15:0] rdata, ram_wdata, ram_rdata;
    logic        cpu_stall, ram_we;
    logic [7:0]  ram_addr;

    ram_port_arbiter dut (
        .Clk(clk), .Rst(rst), .Req({req1, req0}), .We({we1, we0}),
        .Addr0(addr0), .Addr1(addr1), .WData0(wdata0), .WData1(wdata1),
        .Gnt(gnt), .Ack(ack), .RData(rdata), .CpuStall(cpu_stall),
        .RamAddr(ram_addr), .RamWe(ram_we), .RamWData(ram_wdata), .RamRData(ram_rdata)
    );

    always #5 clk = ~clk;

    // Sync-read RAM model: a write is visible to a read issued next cycle
    logic [15:0] mem [256];
    logic [15:0] shadow [256];
    logic [15:0] ram_q = '0;
    assign ram_rdata = ram_q;
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct packed {
        int          acc;
        logic        rd;
        logic [15:0] data;
    } sb_t;

    sb_t         sb0[$], sb1[$];
    logic [24:0] ops0[$], ops1[$];   // {we, addr, data}
    int          gl_owner[$], gl_cyc[$], ack_cyc0[$], ack_cyc1[$];
    logic [1:0]  prev_gnt = 2'b00;
    logic        mon_en = 1'b0;
    int          stall_cnt = 0;
    logic [15:0] last_rd0 = '0;

    task automatic handle_ack(input int p);
        sb_t e;
        if ((p == 0 ? sb0.size() : sb1.size()) == 0) begin
            check_eq(p == 0 ? "ack0_spurious" : "ack1_spurious", 1, 0);
        end else begin
            if (p == 0) e = sb0.pop_front(); else e = sb1.pop_front();
            check_eq(p == 0 ? "ack0_latency" : "ack1_latency", cyc, e.acc + 1);
            if (e.rd) check_eq(p == 0 ? "rdata0" : "rdata1", {16'h0, rdata}, {16'h0, e.data});
            if (p == 0) begin
                ack_cyc0.push_back(cyc);
                if (e.rd) last_rd0 = rdata;
            end else begin
                ack_cyc1.push_back(cyc);
            end
        end
    endtask

    // Monitor: grant exclusivity, stall definition, Ack scoreboard, grant log
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("gnt_exclusive", {31'h0, gnt[0] & gnt[1]}, 0);
            check_eq("cpu_stall", {31'h0, cpu_stall}, {31'h0, req0 & ~gnt[0]});
            if (cpu_stall) stall_cnt++;
            if (ack[0]) handle_ack(0);
            if (ack[1]) handle_ack(1);
            if (gnt != prev_gnt && gnt != 2'b00) begin
                gl_owner.push_back(gnt[1] ? 1 : 0);
                gl_cyc.push_back(cyc);
            end
            prev_gnt = gnt;
        end
    end

    task automatic present(input int p, input logic r, input logic [24:0] op);
        if (p == 0) begin
            req0 = r; we0 = op[24]; addr0 = op[23:16]; wdata0 = op[15:0];
        end else begin
            req1 = r; we1 = op[24]; addr1 = op[23:16]; wdata1 = op[15:0];
        end
    endtask

    task automatic accept(input int p, input logic [24:0] op);
        sb_t e;
        e.acc  = cyc;
        e.rd   = ~op[24];
        e.data = op[24] ? 16'h0 : shadow[op[23:16]];
        if (op[24]) shadow[op[23:16]] = op[15:0];
        if (p == 0) sb0.push_back(e); else sb1.push_back(e);
    endtask

    // Requester: holds Req and the current access until it is granted, then advances
    task automatic drive_port(input int p);
        logic [24:0] op;
        int i = 0;
        int t = 0;
        int n = (p == 0) ? ops0.size() : ops1.size();
        while (i < n && t < 200) begin
            op = (p == 0) ? ops0[i] : ops1[i];
            present(p, 1'b1, op);
            @(negedge clk);
            if (gnt[p]) begin
                accept(p, op);
                i++;
            end
            @(posedge clk); #1;
            t++;
        end
        present(p, 1'b0, 25'h0);
        if (i < n) check_eq(p == 0 ? "drv0_timeout" : "drv1_timeout", i, n);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gl_owner.delete(); gl_cyc.delete(); ack_cyc0.delete(); ack_cyc1.delete();
        stall_cnt = 0;
    endtask

    function automatic logic [24:0] mk(input logic w, input logic [7:0] a, input logic [15:0] d);
        return {w, a, d};
    endfunction

    int s;
    int n_before;
    int exp_first;
    int exp_gnt0_cyc;
    int exp_stall;
    int exp_pre_acks;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 16'hA500 ^ 16'(i);
            shadow[i] = 16'hA500 ^ 16'(i);
        end
        req0 = 1'b1;
        idle(2);
        @(negedge clk);
        check_eq("rst_gnt", {30'h0, gnt}, 0);
        check_eq("rst_ack", {30'h0, ack}, 0);
        check_eq("rst_rdata", {16'h0, rdata}, 0);
        check_eq("rst_stall", {31'h0, cpu_stall}, 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        rst  = 1'b0;
        mon_en = 1'b1;
        idle(1);

        // Tie from reset: CPU first, then loader; next tie alternates back
`ifdef ARB_FIXED_PRIORITY_EN
        exp_first = 1;
`else
        exp_first = 0;
`endif
        for (int k = 0; k < 2; k++) begin
            clear_logs();
            ops0 = '{mk(1'b1, 8'h50 + 8'(k), 16'h1111 + 16'(k)), mk(1'b0, 8'h50 + 8'(k), 16'h0)};
            ops1 = '{mk(1'b1, 8'h60 + 8'(k), 16'h3333 + 16'(k)), mk(1'b0, 8'h02, 16'h0)};
            fork
                drive_port(0);
                drive_port(1);
            join
            idle(3);
            check_eq("tie_grants", gl_owner.size(), 2);
            if (gl_owner.size() >= 2) begin
                check_eq("tie_first", gl_owner[0], exp_first);
                check_eq("tie_second", gl_owner[1], 1 - exp_first);
            end
        end

        // Single write then read of the same address
        clear_logs();
        s = cyc;
        ops0 = '{mk(1'b1, 8'h10, 16'hBEEF), mk(1'b0, 8'h10, 16'h0)};
        drive_port(0);
        idle(3);
        check_eq("single_gnt_cyc", gl_cyc.size() > 0 ? gl_cyc[0] : -1, s + 1);
        check_eq("single_ack_n", ack_cyc0.size(), 2);
        if (ack_cyc0.size() == 2) begin
            check_eq("single_ack1_cyc", ack_cyc0[0], s + 2);
            check_eq("single_ack2_cyc", ack_cyc0[1], s + 3);
        end
        check_eq("single_rdata", {16'h0, last_rd0}, 32'hBEEF);

        // Uncontended burst longer than the burst limit
        clear_logs();
        ops0 = '{mk(1'b1, 8'h20, 16'h0123), mk(1'b1, 8'h21, 16'h4567), mk(1'b1, 8'h22, 16'h89AB),
                 mk(1'b0, 8'h20, 16'h0), mk(1'b0, 8'h21, 16'h0), mk(1'b0, 8'h22, 16'h0)};
        drive_port(0);
        idle(3);
        check_eq("burst_one_grant", gl_owner.size(), 1);
        check_eq("burst_ack_n", ack_cyc0.size(), 6);
        if (ack_cyc0.size() == 6) check_eq("burst_back2back", ack_cyc0[5] - ack_cyc0[0], 5);

        // Loader streams 8 reads while the CPU waits
`ifdef ARB_FIXED_PRIORITY_EN
        exp_gnt0_cyc = 11; exp_stall = 10; exp_pre_acks = 8;
`else
        exp_gnt0_cyc = 6;  exp_stall = 5;  exp_pre_acks = 4;
`endif
        clear_logs();
        ops1.delete();
        for (int i = 0; i < 8; i++) ops1.push_back(mk(1'b0, 8'(i), 16'h0));
        ops0 = '{mk(1'b1, 8'h70, 16'hABCD), mk(1'b0, 8'h70, 16'h0)};
        s = cyc;
        fork
            drive_port(1);
            begin
                @(posedge clk); #1;
                drive_port(0);
            end
        join
        idle(3);
        check_eq("pre_grants", gl_owner.size(), 3);
        if (gl_owner.size() >= 2) begin
            check_eq("pre_first_owner", gl_owner[0], 1);
            check_eq("pre_first_cyc", gl_cyc[0], s + 1);
            check_eq("pre_cpu_owner", gl_owner[1], 0);
            check_eq("pre_cpu_cyc", gl_cyc[1], s + exp_gnt0_cyc);
            n_before = 0;
            foreach (ack_cyc1[i]) if (ack_cyc1[i] < gl_cyc[1]) n_before++;
            check_eq("pre_loader_acks", n_before, exp_pre_acks);
        end
        check_eq("pre_stall_cycles", stall_cnt, exp_stall);
        check_eq("pre_loader_total", ack_cyc1.size(), 8);

        check_eq("sb0_drained", sb0.size(), 0);
        check_eq("sb1_drained", sb1.size(), 0);

        // Reset asserted while a read is being acknowledged and the grant is held
        mon_en = 1'b0;
        present(0, 1'b1, mk(1'b0, 8'h10, 16'h0));
        idle(2);
        @(negedge clk);
        check_eq("mid_pre_ack", {30'h0, ack}, 2'b01);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_gnt", {30'h0, gnt}, 0);
        check_eq("mid_rst_ack", {30'h0, ack}, 0);
        check_eq("mid_rst_rdata", {16'h0, rdata}, 0);
        check_eq("mid_rst_stall", {31'h0, cpu_stall}, 1);
        @(posedge clk); #1;
        present(0, 1'b0, 25'h0);
        rst = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
